// File: rtl/ad9648_controller.sv
// rtl/ad9648_controller.sv - AD9648 dual-channel capture front end (optional peak detect: AD9648_PEAK_EN)
module ad9648_controller #(
  parameter int bit_width   = 14,
  parameter int WAKE_CYCLES = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 enable_in,
  input  logic [bit_width-1:0] data_a_in,
  input  logic [bit_width-1:0] data_b_in,
  input  logic                 overrange_a_in,
  input  logic                 overrange_b_in,
  input  logic                 clr_ovr_in,
  output logic                 adc_enable_out,
  output logic [bit_width-1:0] data_a_out,
  output logic [bit_width-1:0] data_b_out,
  output logic                 valid_out,
  output logic                 ovr_a_out,
  output logic                 ovr_b_out,
  output logic [bit_width-1:0] peak_a_out,
  output logic [bit_width-1:0] peak_b_out
);

  localparam int CW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAKE, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                adc_en_q, adc_en_d;
  logic                valid_q, valid_d;

  logic [bit_width-1:0] in_a_q, in_b_q;
  logic                 or_a_q, or_b_q;
  logic [bit_width-1:0] conv_a, conv_b;
  logic [bit_width-1:0] dout_a_q, dout_a_d, dout_b_q, dout_b_d;
  logic                 ovr_a_q, ovr_a_d, ovr_b_q, ovr_b_d;

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: wake-up sequencing, any drop of enable returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable_in) state_d = ST_WAKE;
      ST_WAKE: begin
        if (!enable_in)       state_d = ST_IDLE;
        else if (cnt_q == '0) state_d = ST_RUN;
      end
      ST_RUN:  if (!enable_in) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/counter next values; valid is gated by enable so it drops with adc_enable
  always_comb begin
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: cnt_d = enable_in ? CNT_LOAD : '0;
      ST_WAKE: begin
        if (!enable_in)       cnt_d = '0;
        else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
      default: cnt_d = '0;
    endcase
    adc_en_d = (state_d != ST_IDLE);
    valid_d  = (state_q == ST_RUN) && enable_in;
  end

  // Control registers driven from the FSM output logic
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q    <= '0;
      adc_en_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      adc_en_q <= adc_en_d;
      valid_q  <= valid_d;
    end
  end

  // Input stage: pins are captured every cycle so A and B share one edge
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      in_a_q <= '0;
      in_b_q <= '0;
      or_a_q <= 1'b0;
      or_b_q <= 1'b0;
    end else begin
      in_a_q <= data_a_in;
      in_b_q <= data_b_in;
      or_a_q <= overrange_a_in;
      or_b_q <= overrange_b_in;
    end
  end

  // Offset binary to two's complement, plus output hold and sticky overrange next values
  always_comb begin
    conv_a   = {~in_a_q[bit_width-1], in_a_q[bit_width-2:0]};
    conv_b   = {~in_b_q[bit_width-1], in_b_q[bit_width-2:0]};
    dout_a_d = valid_d ? conv_a : dout_a_q;
    dout_b_d = valid_d ? conv_b : dout_b_q;
    ovr_a_d  = (valid_d && or_a_q) ? 1'b1 : (clr_ovr_in ? 1'b0 : ovr_a_q);
    ovr_b_d  = (valid_d && or_b_q) ? 1'b1 : (clr_ovr_in ? 1'b0 : ovr_b_q);
  end

  // Output stage registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      dout_a_q <= '0;
      dout_b_q <= '0;
      ovr_a_q  <= 1'b0;
      ovr_b_q  <= 1'b0;
    end else begin
      dout_a_q <= dout_a_d;
      dout_b_q <= dout_b_d;
      ovr_a_q  <= ovr_a_d;
      ovr_b_q  <= ovr_b_d;
    end
  end

`ifdef AD9648_PEAK_EN
  localparam logic [bit_width-1:0] MIN_NEG = {1'b1, {(bit_width-1){1'b0}}};
  localparam logic [bit_width-1:0] MAX_POS = ~MIN_NEG;

  logic [bit_width-1:0] mag_a, mag_b;
  logic [bit_width-1:0] peak_a_q, peak_a_d, peak_b_q, peak_b_d;

  function automatic logic [bit_width-1:0] abs_sat(input logic [bit_width-1:0] s);
    if (s == MIN_NEG)         return MAX_POS;
    else if (s[bit_width-1])  return -s;
    else                      return s;
  endfunction

  // Peak next values: a clear coinciding with a sample restarts from that sample
  always_comb begin
    mag_a    = abs_sat(conv_a);
    mag_b    = abs_sat(conv_b);
    peak_a_d = peak_a_q;
    peak_b_d = peak_b_q;
    if (valid_d) begin
      if (clr_ovr_in || (mag_a > peak_a_q)) peak_a_d = mag_a;
      if (clr_ovr_in || (mag_b > peak_b_q)) peak_b_d = mag_b;
    end else if (clr_ovr_in) begin
      peak_a_d = '0;
      peak_b_d = '0;
    end
  end

  // Peak registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      peak_a_q <= '0;
      peak_b_q <= '0;
    end else begin
      peak_a_q <= peak_a_d;
      peak_b_q <= peak_b_d;
    end
  end

  assign peak_a_out = peak_a_q;
  assign peak_b_out = peak_b_q;
`else
  assign peak_a_out = '0;
  assign peak_b_out = '0;
`endif

  assign adc_enable_out = adc_en_q;
  assign valid_out      = valid_q;
  assign data_a_out     = dout_a_q;
  assign data_b_out     = dout_b_q;
  assign ovr_a_out      = ovr_a_q;
  assign ovr_b_out      = ovr_b_q;

endmodule

// File: tb/tb_ad9648_controller.sv
// tb/tb_ad9648_controller.sv - directed self-checking bench for ad9648_controller
module tb_ad9648_controller;
  localparam int BW = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [BW-1:0] da = '0, db = '0;
  logic          ora = 1'b0, orb = 1'b0, clr = 1'b0;
  logic          adc_en, valid, ovr_a, ovr_b;
  logic [BW-1:0] qa, qb, pa, pb;

  int checks = 0;
  int errors = 0;

  ad9648_controller #(.bit_width(BW), .WAKE_CYCLES(16)) dut (
    .clk_in(clk), .rst_in(rst), .enable_in(en),
    .data_a_in(da), .data_b_in(db),
    .overrange_a_in(ora), .overrange_b_in(orb), .clr_ovr_in(clr),
    .adc_enable_out(adc_en), .data_a_out(qa), .data_b_out(qb),
    .valid_out(valid), .ovr_a_out(ovr_a), .ovr_b_out(ovr_b),
    .peak_a_out(pa), .peak_b_out(pb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges from now until valid rises; returns 999 if it never does
  task automatic wait_valid(output int n);
    n = 999;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (valid) begin
        n = i;
        break;
      end
    end
  endtask

  int n;

  initial begin
    tick(); tick();
    check("rst_adc_en", adc_en, 0);
    check("rst_valid", valid, 0);
    check("rst_data_a", qa, 0);
    check("rst_data_b", qb, 0);
    check("rst_ovr_a", ovr_a, 0);
    check("rst_peak_a", pa, 0);
    rst = 1'b0;
    tick();
    check("idle_adc_en", adc_en, 0);

    // wake-up timing
    en = 1'b1;
    tick();
    check("adc_en_rise", adc_en, 1);
    check("valid_in_wake", valid, 0);
    wait_valid(n);
    check("wake_latency", n, 17);
    tick();
    check("valid_cont1", valid, 1);
    tick();
    check("valid_cont2", valid, 1);

    // conversion ramp, two edges of latency
    da = 14'h0000; db = 14'h0000;
    tick();
    da = 14'h2000; db = 14'h2000;
    tick();
    check("ramp0_a", qa, 14'h2000);
    check("ramp0_b", qb, 14'h2000);
    da = 14'h3FFF; db = 14'h3FFF;
    tick();
    check("ramp1_a", qa, 14'h0000);
    check("ramp1_b", qb, 14'h0000);
    da = 14'h2000; db = 14'h2000;
    tick();
    check("ramp2_a", qa, 14'h1FFF);
    check("ramp2_b", qb, 14'h1FFF);
    tick();

    // sticky overrange with set-wins-over-clear
    ora = 1'b1;
    tick();
    check("ovr_a_not_yet", ovr_a, 0);
    ora = 1'b0; clr = 1'b1;
    tick();
    check("ovr_a_set_wins", ovr_a, 1);
    check("ovr_b_clean", ovr_b, 0);
    clr = 1'b0;
    tick(); tick();
    check("ovr_a_held", ovr_a, 1);
    clr = 1'b1;
    tick();
    check("ovr_a_cleared", ovr_a, 0);
    check("peak_a_clr_load", pa, 0);
    clr = 1'b0;

    // peak detection
    da = 14'h2100;
    tick(); tick();
`ifdef AD9648_PEAK_EN
    check("peak_a_0100", pa, 14'h0100);
`else
    check("peak_a_off", pa, 0);
`endif
    da = 14'h1F00;
    tick(); tick();
`ifdef AD9648_PEAK_EN
    check("peak_a_keep", pa, 14'h0100);
`else
    check("peak_a_off2", pa, 0);
`endif
    da = 14'h0000;
    tick(); tick();
`ifdef AD9648_PEAK_EN
    check("peak_a_sat", pa, 14'h1FFF);
`else
    check("peak_a_off3", pa, 0);
`endif
    check("peak_b_zero", pb, 0);
    check("data_a_minneg", qa, 14'h2000);

    // drop enable mid-stream
    en = 1'b0; da = 14'h1234;
    tick();
    check("drop_valid", valid, 0);
    check("drop_adc_en", adc_en, 0);
    check("drop_hold_a", qa, 14'h2000);
    tick();
    check("drop_hold_a2", qa, 14'h2000);
    check("drop_hold_b", qb, 14'h0000);

    // re-enable repeats full wake-up, with a toggle during WAKE
    en = 1'b1;
    tick(); tick(); tick();
    en = 1'b0;
    tick();
    check("wake_abort", adc_en, 0);
    en = 1'b1;
    tick();
    check("re_adc_en", adc_en, 1);
    wait_valid(n);
    check("rewake_latency", n, 17);
    check("rewake_data_a", qa, 14'h3234);

    // reset in RUN
    ora = 1'b1;
    tick();
    ora = 1'b0;
    tick();
    check("pre_rst_ovr", ovr_a, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_adc_en", adc_en, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_data_a", qa, 0);
    check("mid_rst_data_b", qb, 0);
    check("mid_rst_ovr_a", ovr_a, 0);
    check("mid_rst_peak_a", pa, 0);
    rst = 1'b0;
    tick();
    check("post_rst_idle_valid", valid, 0);
    check("post_rst_wake", adc_en, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
